// File: rtl/fp_add_sequencer.sv
// Multi-cycle IEEE-754 single-precision adder: IDLE/ALIGN/ADD/NORM/ROUND/DONE over one shared datapath.
// FP_ROUND_RNE_EN selects round-to-nearest-even; when it is undefined, ROUND truncates.

// 24-bit leading-one priority encoder: returns the leading-zero count (0..23) of a non-zero input.
module fp_lzc24 (
  input  logic [23:0] din,
  output logic [4:0]  lzc
);
  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i < 24; i++)
      if (din[i]) lzc = 5'(23 - i);
  end
endmodule

module fp_add_sequencer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

`ifdef FP_ROUND_RNE_EN
  localparam bit RNE_EN = 1'b1;
`else
  localparam bit RNE_EN = 1'b0;
`endif

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t             state;
  logic [31:0]        a_r, b_r;
  logic               spec_v;
  logic [31:0]        spec_res;
  logic               sgn_r, sub_r, zero_r;
  logic signed [9:0]  e_r;
  logic [26:0]        op1_r, op2_r;   // {sig24, G, R, S}
  logic [27:0]        sum_r;          // {carry, sig24, G, R, S}
  logic [23:0]        sig_r;
  logic [2:0]         grs_r;

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  // ---------------- ALIGN: unpack, specials, swap, shift ----------------
  logic [7:0]  ea, eb, e1, e2, diff;
  logic [22:0] ma, mb;
  logic [30:0] ka, kb;
  logic [23:0] sig_a, sig_b, sig1, sig2;
  logic        s1, s2, swap, a_nan, b_nan, a_inf, b_inf;
  logic [49:0] sh;
  logic [26:0] al2;
  logic        al_spec;
  logic [31:0] al_spec_res;

  always_comb begin
    ea = a_r[30:23];  ma = a_r[22:0];
    eb = b_r[30:23];  mb = b_r[22:0];
    a_nan = (ea == 8'hFF) && (ma != 23'd0);
    b_nan = (eb == 8'hFF) && (mb != 23'd0);
    a_inf = (ea == 8'hFF) && (ma == 23'd0);
    b_inf = (eb == 8'hFF) && (mb == 23'd0);
    // exponent-0 inputs are flushed to zero, so they also rank as zero
    ka    = (ea == 8'd0) ? 31'd0 : a_r[30:0];
    kb    = (eb == 8'd0) ? 31'd0 : b_r[30:0];
    sig_a = (ea == 8'd0) ? 24'd0 : {1'b1, ma};
    sig_b = (eb == 8'd0) ? 24'd0 : {1'b1, mb};
    swap  = (kb > ka);
    s1    = swap ? b_r[31] : a_r[31];
    s2    = swap ? a_r[31] : b_r[31];
    e1    = swap ? eb : ea;
    e2    = swap ? ea : eb;
    sig1  = swap ? sig_b : sig_a;
    sig2  = swap ? sig_a : sig_b;
    diff  = e1 - e2;
    sh    = {sig2, 26'd0} >> diff;
    if (diff >= 8'd26) al2 = {26'd0, |sig2};
    else               al2 = {sh[49:24], |sh[23:0]};

    al_spec     = 1'b0;
    al_spec_res = QNAN;
    if (a_nan || b_nan || (a_inf && b_inf && (a_r[31] != b_r[31]))) begin
      al_spec = 1'b1;
    end else if (a_inf) begin
      al_spec = 1'b1;  al_spec_res = a_r;
    end else if (b_inf) begin
      al_spec = 1'b1;  al_spec_res = b_r;
    end
  end

  // ---------------- NORM ----------------
  logic [4:0]        enc_z, z;
  logic [26:0]       shl;
  logic [23:0]       n_sig;
  logic [2:0]        n_grs;
  logic signed [9:0] n_e;
  logic              n_zero;

  fp_lzc24 u_lzc (.din(sum_r[26:3]), .lzc(enc_z));

  always_comb begin
    n_sig  = sum_r[26:3];
    n_grs  = sum_r[2:0];
    n_e    = e_r;
    n_zero = 1'b0;
    z      = enc_z;
    shl    = sum_r[26:0];
    if (sum_r[27]) begin
      n_sig = sum_r[27:4];
      n_grs = {sum_r[3], sum_r[2], |sum_r[1:0]};
      n_e   = e_r + 10'sd1;
    end else if (sum_r[26:0] == 27'd0) begin
      n_zero = 1'b1;
    end else begin
      // a cancellation can leave only the guard bit set; that needs a full 24-bit shift
      if (sum_r[26:3] == 24'd0) z = 5'd24;
      shl   = sum_r[26:0] << z;
      n_sig = shl[26:3];
      n_grs = shl[2:0];
      n_e   = e_r - signed'({5'd0, z});
    end
  end

  // ---------------- ROUND + pack ----------------
  logic              inc;
  logic [24:0]       rs;
  logic [23:0]       f_sig;
  logic signed [9:0] f_e;
  logic [31:0]       packed_res;

  always_comb begin
    inc = RNE_EN & grs_r[2] & (grs_r[1] | grs_r[0] | sig_r[0]);
    rs  = {1'b0, sig_r} + {24'd0, inc};
    if (rs[24]) begin
      f_sig = rs[24:1];
      f_e   = e_r + 10'sd1;
    end else begin
      f_sig = rs[23:0];
      f_e   = e_r;
    end
    if (spec_v)               packed_res = spec_res;
    else if (zero_r)          packed_res = 32'd0;
    else if (f_e >= 10'sd255) packed_res = {sgn_r, 8'hFF, 23'd0};
    else if (f_e <= 10'sd0)   packed_res = {sgn_r, 31'd0};
    else                      packed_res = {sgn_r, f_e[7:0], f_sig[22:0]};
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= 32'd0;
      a_r       <= 32'd0;
      b_r       <= 32'd0;
      spec_v    <= 1'b0;
      spec_res  <= 32'd0;
      sgn_r     <= 1'b0;
      sub_r     <= 1'b0;
      zero_r    <= 1'b0;
      e_r       <= 10'sd0;
      op1_r     <= 27'd0;
      op2_r     <= 27'd0;
      sum_r     <= 28'd0;
      sig_r     <= 24'd0;
      grs_r     <= 3'd0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          state <= ALIGN;
        end
        ALIGN: begin
          spec_v   <= al_spec;
          spec_res <= al_spec_res;
          sgn_r    <= s1;
          sub_r    <= s1 ^ s2;
          e_r      <= signed'({2'b00, e1});
          op1_r    <= {sig1, 3'b000};
          op2_r    <= al2;
          state    <= ADD;
        end
        ADD: begin
          sum_r <= sub_r ? ({1'b0, op1_r} - {1'b0, op2_r})
                         : ({1'b0, op1_r} + {1'b0, op2_r});
          state <= NORM;
        end
        NORM: begin
          sig_r  <= n_sig;
          grs_r  <= n_grs;
          e_r    <= n_e;
          zero_r <= n_zero;
          state  <= ROUND;
        end
        ROUND: begin
          result    <= packed_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed self-checking bench for fp_add_sequencer; tie-rounding expectation follows FP_ROUND_RNE_EN.
module tb_fp_add_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b, result;
  int checks = 0;
  int failures = 0;

  fp_add_sequencer #(.W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Presents an operand pair from a negedge and holds it through the accepting posedge.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      in_valid = 1'b1; a = av; b = bv;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  // Cycle n is the period after the n-th edge following the accept edge (cycle 0 ends at accept).
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] res, output int cyc, output logic [7:0] busy_hist);
    bit ok;
    cyc = 99; res = 32'hDEAD_BEEF; busy_hist = 8'd0;
    issue(av, bv, ok);
    if (ok) begin
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (i < 8) busy_hist[i] = busy;
        if (out_valid) begin cyc = i; break; end
      end
      res = result;
      if (out_ready && cyc != 99) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=00000000", result); end
    rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic_add();
    logic [31:0] r; int c; logic [7:0] bh;
    out_ready = 1'b1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_c0 got=%b want=0", busy); end
    run_op(32'h3F80_0000, 32'h3F80_0000, r, c, bh);
    checks++; if (r !== 32'h4000_0000) begin failures++; $display("FAIL basic_1p1 got=%h want=40000000", r); end
    checks++; if (c !== 5) begin failures++; $display("FAIL basic_latency got=%0d want=5", c); end
    checks++; if (bh[5:1] !== 5'b11111) begin failures++; $display("FAIL basic_busy_c1_5 got=%b want=11111", bh[5:1]); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL basic_back_idle got busy=%b in_ready=%b want 0/1", busy, in_ready); end
  endtask

  task automatic test_cancel();
    logic [31:0] r; int c; logic [7:0] bh;
    out_ready = 1'b1;
    run_op(32'h3F80_0000, 32'hBF40_0000, r, c, bh);
    checks++; if (r !== 32'h3E80_0000) begin failures++; $display("FAIL cancel_lshift2 got=%h want=3e800000", r); end
    run_op(32'h3F80_0000, 32'hBF80_0000, r, c, bh);
    checks++; if (r !== 32'h0000_0000) begin failures++; $display("FAIL cancel_zero got=%h want=00000000", r); end
    run_op(32'h3F80_0000, 32'h4000_0000, r, c, bh);
    checks++; if (r !== 32'h4040_0000) begin failures++; $display("FAIL swap_1p2 got=%h want=40400000", r); end
  endtask

  task automatic test_round();
    logic [31:0] r, exp_r; int c; logic [7:0] bh;
`ifdef FP_ROUND_RNE_EN
    exp_r = 32'h3F80_0002;
`else
    exp_r = 32'h3F80_0001;
`endif
    out_ready = 1'b1;
    run_op(32'h3F80_0001, 32'h3380_0000, r, c, bh);
    checks++; if (r !== exp_r) begin failures++; $display("FAIL round_tie got=%h want=%h", r, exp_r); end
  endtask

  task automatic test_specials();
    logic [31:0] r; int c; logic [7:0] bh;
    out_ready = 1'b1;
    run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, r, c, bh);
    checks++; if (r !== 32'h7F80_0000) begin failures++; $display("FAIL overflow_inf got=%h want=7f800000", r); end
    run_op(32'h7F80_0000, 32'hFF80_0000, r, c, bh);
    checks++; if (r !== 32'h7FC0_0000) begin failures++; $display("FAIL inf_minus_inf got=%h want=7fc00000", r); end
    checks++; if (c !== 5) begin failures++; $display("FAIL special_latency got=%0d want=5", c); end
    run_op(32'h7FC0_0001, 32'h3F80_0000, r, c, bh);
    checks++; if (r !== 32'h7FC0_0000) begin failures++; $display("FAIL nan_in got=%h want=7fc00000", r); end
    run_op(32'hFF80_0000, 32'h3F80_0000, r, c, bh);
    checks++; if (r !== 32'hFF80_0000) begin failures++; $display("FAIL inf_plus_fin got=%h want=ff800000", r); end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; int c; logic [7:0] bh; bit bad;
    out_ready = 1'b0;
    run_op(32'h3F80_0000, 32'h4000_0000, r, c, bh);
    checks++; if (r !== 32'h4040_0000) begin failures++; $display("FAIL bp_result got=%h want=40400000", r); end
    bad = 1'b0;
    in_valid = 1'b1; a = 32'h4000_0000; b = 32'h4000_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || result !== 32'h4040_0000 || in_ready !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL bp_hold got out_valid=%b result=%h in_ready=%b want 1/40400000/0", out_valid, result, in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_release got in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_no_second_op got busy=%b want=0", busy); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] r; int c; logic [7:0] bh; bit ok, seen;
    out_ready = 1'b1;
    issue(32'h3F80_0000, 32'h3F80_0000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_issue got=timeout want=accept"); end
    repeat (3) @(negedge clk);   // cycle 3: NORM
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_idle got busy=%b out_valid=%b want 0/0", busy, out_valid); end
    @(negedge clk);
    rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_in_ready got=%b want=1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL mid_rst_no_out got out_valid=1 want=0"); end
    run_op(32'h3F80_0000, 32'hBF40_0000, r, c, bh);
    checks++; if (r !== 32'h3E80_0000 || c !== 5) begin failures++; $display("FAIL mid_rst_next got=%h/%0d want=3e800000/5", r, c); end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_cancel();
    test_round();
    test_specials();
    test_backpressure();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
